// File: rtl/uart_frame_rx_if.sv
// Receive-side bundle for uart_frame_rx: oversampling strobe, serial line,
// frame configuration, and the reported word with its status flags.
interface uart_frame_rx_if;
    logic       baud_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    // Drives the line and configuration; consumes reported frames.
    modport master (
        output baud_tick, rx_in, parity_type, stop_bits, data_length,
        input  data_out, data_valid, parity_error, stop_error, busy
    );

    // The receiver itself.
    modport slave (
        input  baud_tick, rx_in, parity_type, stop_bits, data_length,
        output data_out, data_valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART receiver and frame checker. Oversamples the synchronized line,
// deserializes 7/8 data bits MSB first, checks optional parity and one or
// two stop bits, then reports the word and flags with a one-clk valid.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a synchronized falling edge on the line
//   S_START  | timing to mid start bit; high there means false start
//   S_DATA   | sampling data bits mid-bit, shifting in MSB first
//   S_PARITY | sampling the parity bit and checking it against the data
//   S_STOP1  | sampling the first stop bit
//   S_STOP2  | sampling the second stop bit (two-stop mode only)
//   S_DONE   | one clk: publish word and flags, pulse data_valid
module uart_frame_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_frame_rx_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [2:0]    bcnt, bcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [1:0]    cfg_ptype, cfg_ptype_nxt;
    logic          cfg_two, cfg_two_nxt;
    logic          cfg_len8, cfg_len8_nxt;
    logic          perr_r, perr_nxt;
    logic          serr_r, serr_nxt;
    logic [7:0]    dout_r, dout_nxt;
    logic          vout_r, vout_nxt;
    logic          perr_o, perr_o_nxt;
    logic          serr_o, serr_o_nxt;

    logic       sync1, rx_s, rx_d;
    logic [2:0] sync_vld;
    logic       fall, mid_start, mid_bit, par_en;
    logic [2:0] last_idx;

    // Two-flop synchronizer plus edge-detect flop; sync_vld tracks how many
    // stages hold real line samples so a line already low when reset is
    // released is not mistaken for a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b1;
            sync_vld <= 3'b000;
        end else begin
            sync1    <= bus.rx_in;
            rx_s     <= sync1;
            rx_d     <= rx_s;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign fall      = sync_vld[2] & rx_d & ~rx_s;
    assign mid_start = bus.baud_tick && (tcnt == T_HALF);
    assign mid_bit   = bus.baud_tick && (tcnt == T_LAST);
    assign par_en    = ^cfg_ptype;
    assign last_idx  = cfg_len8 ? 3'd7 : 3'd6;

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_nxt     = state;
        tcnt_nxt      = tcnt;
        bcnt_nxt      = bcnt;
        shreg_nxt     = shreg;
        cfg_ptype_nxt = cfg_ptype;
        cfg_two_nxt   = cfg_two;
        cfg_len8_nxt  = cfg_len8;
        perr_nxt      = perr_r;
        serr_nxt      = serr_r;
        dout_nxt      = dout_r;
        vout_nxt      = 1'b0;
        perr_o_nxt    = perr_o;
        serr_o_nxt    = serr_o;

        if (bus.baud_tick && state != S_IDLE && state != S_DONE) begin
            tcnt_nxt = tcnt + TW'(1);
        end

        case (state)
            S_IDLE: begin
                if (fall) begin
                    cfg_ptype_nxt = bus.parity_type;
                    cfg_two_nxt   = bus.stop_bits;
                    cfg_len8_nxt  = bus.data_length;
                    tcnt_nxt      = '0;
                    perr_nxt      = 1'b0;
                    serr_nxt      = 1'b0;
                    state_nxt     = S_START;
                end
            end
            S_START: begin
                if (mid_start) begin
                    tcnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        bcnt_nxt  = '0;
                        shreg_nxt = '0;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    tcnt_nxt  = '0;
                    shreg_nxt = {shreg[6:0], rx_s};
                    bcnt_nxt  = bcnt + 3'd1;
                    if (bcnt == last_idx) begin
                        state_nxt = par_en ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (mid_bit) begin
                    tcnt_nxt  = '0;
                    perr_nxt  = ((^shreg) ^ rx_s) != (cfg_ptype == 2'b01);
                    state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                if (mid_bit) begin
                    tcnt_nxt  = '0;
                    serr_nxt  = serr_r | ~rx_s;
                    state_nxt = cfg_two ? S_STOP2 : S_DONE;
                end
            end
            S_STOP2: begin
                if (mid_bit) begin
                    tcnt_nxt  = '0;
                    serr_nxt  = serr_r | ~rx_s;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                dout_nxt   = shreg;
                perr_o_nxt = perr_r;
                serr_o_nxt = serr_r;
                vout_nxt   = 1'b1;
                tcnt_nxt   = '0;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters, latched configuration and reported outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            cfg_ptype <= '0;
            cfg_two   <= 1'b0;
            cfg_len8  <= 1'b0;
            perr_r    <= 1'b0;
            serr_r    <= 1'b0;
            dout_r    <= '0;
            vout_r    <= 1'b0;
            perr_o    <= 1'b0;
            serr_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            bcnt      <= bcnt_nxt;
            shreg     <= shreg_nxt;
            cfg_ptype <= cfg_ptype_nxt;
            cfg_two   <= cfg_two_nxt;
            cfg_len8  <= cfg_len8_nxt;
            perr_r    <= perr_nxt;
            serr_r    <= serr_nxt;
            dout_r    <= dout_nxt;
            vout_r    <= vout_nxt;
            perr_o    <= perr_o_nxt;
            serr_o    <= serr_o_nxt;
        end
    end

    assign bus.data_out     = dout_r;
    assign bus.data_valid   = vout_r;
    assign bus.parity_error = perr_o;
    assign bus.stop_error   = serr_o;
    assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames from the test plan
// followed by randomized frames, compared against a frame-level model.
module tb_uart_frame_rx;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_frame_rx_if bus ();

    uart_frame_rx #(.OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Baud strobe: one clk in every TICK_DIV, changed on the falling edge.
    int div = 0;
    always @(negedge clk) begin
        div = (div + 1) % TICK_DIV;
        bus.baud_tick = (div == 0);
    end

    // Monitor: capture every reported frame, count double-width pulses and
    // clocks on which busy was high.
    logic [9:0] got [0:255];
    int   got_n    = 0;
    int   dbl      = 0;
    int   busy_cnt = 0;
    logic prev_v   = 1'b0;
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            got[got_n[7:0]] = {bus.data_out, bus.parity_error, bus.stop_error};
            got_n = got_n + 1;
            if (prev_v) dbl = dbl + 1;
        end
        prev_v = bus.data_valid;
        if (bus.busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word, parity flag and stop flag from the frame contents.
    function automatic logic [9:0] model(input logic [7:0] d, input bit len8,
                                         input logic [1:0] pt, input bit two,
                                         input bit pbit, input bit s1, input bit s2);
        logic [7:0] dm;
        int ones;
        bit perr, serr;
        dm   = len8 ? d : {1'b0, d[6:0]};
        ones = $countones(dm) + (pbit ? 1 : 0);
        if (pt == 2'b01)      perr = (ones % 2) != 1;
        else if (pt == 2'b10) perr = (ones % 2) != 0;
        else                  perr = 1'b0;
        serr = !s1 || (two && !s2);
        return {dm, perr, serr};
    endfunction

    task automatic send_bit(input bit b);
        int n;
        bus.rx_in = b;
        n = 0;
        while (n < OS) begin
            @(posedge clk);
            if (bus.baud_tick) n++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit len8, input logic [1:0] pt,
                              input bit two, input bit pbit, input bit s1, input bit s2,
                              input bit scramble);
        bus.parity_type = pt;
        bus.stop_bits   = two;
        bus.data_length = len8;
        send_bit(1'b0);
        if (scramble) begin
            bus.parity_type = 2'($urandom);
            bus.stop_bits   = 1'($urandom);
            bus.data_length = 1'($urandom);
        end
        for (int i = (len8 ? 7 : 6); i >= 0; i--) send_bit(d[i]);
        if (pt == 2'b01 || pt == 2'b10) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        bus.rx_in = 1'b1;
    endtask

    int rd = 0;
    task automatic expect_frame(input string tag, input logic [9:0] exp);
        int t;
        t = 0;
        while (got_n == rd && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_arrive"}, 32'(got_n), 32'(rd + 1));
        if (got_n > rd) begin
            chk({tag, "_data"}, 32'(got[rd[7:0]][9:2]), 32'(exp[9:2]));
            chk({tag, "_perr"}, 32'(got[rd[7:0]][1]), 32'(exp[1]));
            chk({tag, "_serr"}, 32'(got[rd[7:0]][0]), 32'(exp[0]));
            rd = got_n;
        end
    endtask

    task automatic idle_bits(input int nb);
        bus.rx_in = 1'b1;
        repeat (nb * OS * TICK_DIV) @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;
        logic [7:0] d;
        bit len8, two, pbit, s1, s2;
        logic [1:0] pt;

        bus.rx_in       = 1'b1;
        bus.parity_type = 2'b00;
        bus.stop_bits   = 1'b0;
        bus.data_length = 1'b1;
        rst             = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_perr", 32'(bus.parity_error), 32'h0);
        chk("rst_serr", 32'(bus.stop_error), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_bits(1);

        // 8-bit, no parity, one stop: 0,11010110,1 -> D6
        send_frame(8'hD6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_frame("t1", model(8'hD6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        chk("t1_data_const", 32'(bus.data_out), 32'hD6);
        idle_bits(1);

        // 7-bit odd parity two stops, good then bad parity bit
        send_frame(8'h66, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_frame("t2a", model(8'h66, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1));
        idle_bits(1);
        send_frame(8'h66, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_frame("t2b", model(8'h66, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1));
        chk("t2b_perr_const", 32'(bus.parity_error), 32'h1);
        idle_bits(1);

        // 8-bit even parity, stop bit low
        send_frame(8'hD6, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_frame("t3", model(8'hD6, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1));
        idle_bits(2);

        // Glitch shorter than half a bit: busy blips, no frame
        @(posedge clk);
        #1 bus.rx_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_pre", 32'(bus.busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_rise", 32'(bus.busy), 32'h1);
        repeat (3 * TICK_DIV - 3) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        repeat (2 * OS * TICK_DIV) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_fall", 32'(bus.busy), 32'h0);
        chk("glitch_no_frame", 32'(got_n), 32'(rd));
        idle_bits(1);

        // Back-to-back frames, no idle gap
        send_frame(8'hD6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h2A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        chk("b2b_count", 32'(got_n), 32'(rd + 2));
        if (got_n >= rd + 2) begin
            chk("b2b_first", 32'(got[rd[7:0]]), 32'(model(8'hD6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
            chk("b2b_second", 32'(got[(rd + 1) & 255]), 32'(model(8'h2A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
        end
        rd = got_n;

        // Reset during data bits with the line low; stays low after release
        bus.parity_type = 2'b00;
        bus.stop_bits   = 1'b0;
        bus.data_length = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_data", 32'(bus.data_out), 32'h0);
        chk("mrst_valid", 32'(bus.data_valid), 32'h0);
        chk("mrst_perr", 32'(bus.parity_error), 32'h0);
        chk("mrst_serr", 32'(bus.stop_error), 32'h0);
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        snap = busy_cnt;
        repeat (3 * OS * TICK_DIV) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        idle_bits(2);
        chk("mrst_no_busy", 32'(busy_cnt), 32'(snap));
        chk("mrst_no_frame", 32'(got_n), 32'(rd));
        send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_frame("mrst_fresh", model(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        idle_bits(1);

        // Randomized frames; configuration scrambled after the start bit
        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            len8 = 1'($urandom);
            pt   = 2'($urandom);
            two  = 1'($urandom);
            pbit = 1'($urandom);
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            send_frame(d, len8, pt, two, pbit, s1, s2, 1'b1);
            expect_frame($sformatf("rnd%0d", k), model(d, len8, pt, two, pbit, s1, s2));
            idle_bits(1);
        end

        chk("valid_single_clk", 32'(dbl), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial receiver and frame checker for the team's UART: the receive-side counterpart of the frame generator. Oversamples the line, detects the start bit, deserializes 7 or 8 data bits (MSB first, the generator's bit order), and checks the optional parity bit and 1 or 2 stop bits. Presents the data word with error flags as a one-cycle valid pulse to the downstream receive logic or FIFO. Uses the same `parity_type` / `stop_bits` / `data_length` configuration encoding as the transmit path.

## Interface
- OVERSAMPLE, 16: `baud_tick` pulses per bit period; even, ≥ 4.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 = reset.
- baud_tick  in  1  one-clk strobe at OVERSAMPLE × baud rate.
- rx_in  in  1  serial line, asynchronous to clk, idle high.
- parity_type  in  2  00/11 = no parity, 01 = odd, 10 = even.
- stop_bits  in  1  0 = one stop bit, 1 = two.
- data_length  in  1  0 = 7 data bits, 1 = 8.
- data_out  out  8  received word, LSB-aligned; bit 7 = 0 in 7-bit mode.
- data_valid  out  1  one-clk pulse; `data_out` and error flags valid.
- parity_error  out  1  parity mismatch on the frame being reported.
- stop_error  out  1  framing error: any stop bit sampled low.
- busy  out  1  high from start-bit detection until frame completion or abort.

## Operation
- `rx_in` passes through a 2-FF synchronizer (reset to 1), then one extra flop for edge detection.
- Sampling: tick counter `tcnt` (0..OVERSAMPLE-1) advances only on `baud_tick`. A bit is sampled when `tcnt == OVERSAMPLE/2-1` for the start bit, then every OVERSAMPLE ticks after that (mid-bit).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE: on a synchronized falling edge (previous 1, current 0), latch `parity_type`, `stop_bits` and `data_length`; clear `tcnt`; go to START. A line held low (break) does not retrigger; a new edge is required.
  - START: at mid-bit, line = 1 is a false start, so return to IDLE with no `data_valid`. Line = 0 goes to DATA with the bit counter at 0.
  - DATA: shift sampled bits in MSB first, so the first data bit lands in bit 6 (7-bit mode) or bit 7 (8-bit mode). After 7 or 8 bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compute the XOR of the data bits and the parity bit. Odd mode requires 1; even mode requires 0. A mismatch sets the internal parity error. Then go to STOP1.
  - STOP1: sample the line; 0 sets the internal stop error. Go to STOP2 if two stop bits, else DONE.
  - STOP2: same check as STOP1, then go to DONE.
  - DONE: one clk. Drive `data_out` and both flags, pulse `data_valid`, return to IDLE.
- Errors do not suppress `data_valid`. The frame is always reported with its flags.
- Configuration inputs are ignored mid-frame; only the values latched at start detection apply.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `parity_error` = 0, `stop_error` = 0, `busy` = 0, state IDLE, counters 0, synchronizer = 1.
- `busy` rises 1 clk after the synchronized falling edge.
- `data_valid` rises exactly 1 clk after the clk on which the final stop-bit sample occurs, and lasts 1 clk.
- `data_out` and the flags hold their values until the next DONE; they are not cleared at the next frame start.
- End-to-end latency: 2 clk synchronizer + 1 clk edge detect + start detect + mid-bit sampling.
- Reset asserted mid-frame: immediate return to the reset state. No partial `data_valid` is produced.
- A start edge may be accepted the first clk after DONE; back-to-back frames are supported with no idle gap.

## Test plan
- 8-bit, no parity, 1 stop, serial 0,1,1,0,1,0,1,1,0,1 → `data_out` = 8'hD6, `data_valid` single pulse, both flags 0.
- 7-bit, odd parity, 2 stop, data 7'h66 (four 1s), parity bit 1, stops 1,1 → `data_out` = 8'h66, `parity_error` = 0. Repeat with parity bit 0 → `parity_error` = 1, `data_valid` still pulses.
- 8-bit, even parity, 1 stop, 8'hD6 with parity bit 1, stop bit 0 → `data_out` = 8'hD6, `parity_error` = 0, `stop_error` = 1.
- Glitch: `rx_in` low for 3 ticks (< OVERSAMPLE/2), then high → `busy` pulses, then returns to 0; no `data_valid`.
- Two frames back-to-back (8'hD6, then 8'h2A, 8-bit, no parity) → two `data_valid` pulses with correct data.
- `rst` driven low during DATA of a frame → all outputs at reset values. Line held low afterwards, then rising → no frame is reported until a fresh falling edge.
